sd_cmd_serializer: RTL and testbench
====================================

SD_CMD_SERIALIZER -- requirements
Module: sd_cmd_serializer

Interface
REQ-001 Parameter DIV, default 1, sets bit period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  one-cycle request to send a frame; sampled only while ready=1.
REQ-005 cmd_idx  input  6  command index, captured on accepted start.
REQ-006 cmd_arg  input  32  command argument, captured on accepted start.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 sda_o  output  1  serial command line, MSB first.
REQ-009 sda_oe  output  1  line drive enable, high while a frame bit is on sda_o.
REQ-010 crc_rst  output  1  one-cycle clear pulse to the downstream CRC-7 stage.
REQ-011 crc_en  output  1  CRC-7 shift enable.
REQ-012 crc_bit  output  1  serial data to the CRC-7 stage; equals sda_o.
REQ-013 crc_i  input  7  CRC-7 remainder returned by the CRC-7 stage, polynomial x^7+x^3+1.
REQ-014 done  output  1  one-cycle pulse after the end bit period completes.

Function
REQ-015 States SHALL be IDLE, CLR, SHIFT, CRC, STOP, DONE.
REQ-016 IDLE: start=1 latches {2'b01, cmd_idx, cmd_arg} into a 40-bit shift register, then goes to CLR.
REQ-017 CLR: one cycle, crc_rst=1, sda_oe=0, then SHIFT.
REQ-018 SHIFT: 40 bits, MSB first; each bit held on sda_o for DIV cycles.
REQ-019 crc_en SHALL pulse in the last cycle of each SHIFT bit period only, with crc_bit equal to that bit: exactly 40 pulses per frame.
REQ-020 On leaving SHIFT, crc_i SHALL be captured; CRC sends captured bits 6..0 for DIV cycles each, with crc_en=0.
REQ-021 STOP: sda_o=1 for DIV cycles, sda_oe=1.
REQ-022 DONE: one cycle, done=1, sda_oe=0, sda_o=1, then IDLE.
REQ-023 Frame length SHALL be 48 bit periods; start-accept to done latency SHALL be 48*DIV+2 cycles.
REQ-024 Outside SHIFT, CRC and STOP: sda_o=1, sda_oe=0, crc_en=0.
REQ-025 start while ready=0 SHALL be ignored and has no effect on the frame in progress.
REQ-026 Bit-period counter SHALL count 0..DIV-1 and wrap; with DIV=1 every cycle is a bit boundary.
REQ-027 A new start in the cycle after done SHALL be accepted; back-to-back frames are legal.
REQ-028 cmd_idx and cmd_arg changes after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE in any state, including mid-frame.
REQ-030 Reset values: ready=1, sda_o=1, sda_oe=0, crc_rst=0, crc_en=0, crc_bit=1, done=0, counters and shift register zero.
REQ-031 A frame interrupted by reset SHALL NOT produce done.

Configuration
REQ-032 Macro SD_CMD_SERIALIZER_ABORT_EN SHALL control the abort feature.
REQ-033 Defined: adds input port abort (1 bit). abort=1 in any state other than IDLE returns to IDLE next cycle with sda_oe=0 and a one-cycle crc_rst=1 pulse; no done.
REQ-034 Defined: abort and start in the same IDLE cycle SHALL give abort priority; start is ignored.
REQ-035 Not defined: port abort is absent; every accepted frame runs to done.

Verification
REQ-036 DIV=1, cmd_idx=0, cmd_arg=0, bench CRC-7 model -> sda_o frame 0x40_00000000_95, done 50 cycles after start.
REQ-037 DIV=1, cmd_idx=8, cmd_arg=0x000001AA -> frame 0x48_000001AA_87; 40 crc_en pulses counted.
REQ-038 DIV=4, cmd_idx=17, cmd_arg=0 -> frame 0x51_00000000_55; each bit stable for 4 cycles; done 194 cycles after start.
REQ-039 start pulsed at bit 20 of an active frame -> frame unchanged, ready stays 0 until done.
REQ-040 rst=0 during CRC state -> next cycle ready=1, sda_oe=0, sda_o=1; no done; next start sends a correct frame.
REQ-041 With SD_CMD_SERIALIZER_ABORT_EN defined, abort at bit 10 -> IDLE next cycle, crc_rst pulse, no done; following CMD0 frame = 0x40_00000000_95.

Source files
------------

// File: rtl/sd_cmd_serializer.sv
// sd_cmd_serializer: SD command line serializer (48-bit frame, external CRC-7 stage).
// Optional abort input enabled by SD_CMD_SERIALIZER_ABORT_EN.
module sd_cmd_serializer #(
  parameter int DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SD_CMD_SERIALIZER_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  crc_i,
  output logic        ready,
  output logic        sda_o,
  output logic        sda_oe,
  output logic        crc_rst,
  output logic        crc_en,
  output logic        crc_bit,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, CRC, STOP, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [5:0]  bit_q;
  logic [39:0] sr_q;
  logic [6:0]  crc_q, crc_cur;
  logic        abt_q, blk, kill, accept, bit_end, frame, first;
`ifdef SD_CMD_SERIALIZER_ABORT_EN
  assign blk = abort;
`else
  assign blk = 1'b0;
`endif
  assign kill    = blk & (state_q != IDLE);
  assign accept  = start & (state_q == IDLE) & ~blk;
  assign bit_end = cnt_q == 8'(DIV - 1);
  assign frame   = (state_q == SHIFT) | (state_q == CRC) | (state_q == STOP);
  // The CRC stage's remainder only includes the last data bit one cycle after SHIFT ends
  assign first   = (state_q == CRC) & (bit_q == 6'd0) & (cnt_q == 8'd0);
  assign crc_cur = first ? crc_i : crc_q;
  always_comb begin
    state_d = kill ? IDLE :
              accept ? CLR :
              (state_q == CLR) ? SHIFT :
              (state_q == SHIFT && bit_end && bit_q == 6'd39) ? CRC :
              (state_q == CRC && bit_end && bit_q == 6'd6) ? STOP :
              (state_q == STOP && bit_end) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
    ready   = state_q == IDLE;
    sda_oe  = frame;
    sda_o   = (state_q == SHIFT) ? sr_q[39] : (state_q == CRC) ? crc_cur[6] : 1'b1;
    crc_bit = sda_o;
    crc_en  = (state_q == SHIFT) & bit_end;
    crc_rst = (state_q == CLR) | abt_q;
    done    = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      crc_q   <= '0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      abt_q   <= kill;
      cnt_q   <= (frame && !bit_end && state_d == state_q) ? cnt_q + 8'd1 : '0;
      bit_q   <= (state_d != state_q) ? '0 : (frame && bit_end) ? bit_q + 6'd1 : bit_q;
      if (accept)
        sr_q <= {2'b01, cmd_idx, cmd_arg};
      else if (state_q == SHIFT && bit_end)
        sr_q <= {sr_q[38:0], 1'b0};
      if (state_q == CRC)
        crc_q <= bit_end ? {crc_cur[5:0], 1'b0} : crc_cur;
    end
  end
endmodule

// File: tb/tb_sd_cmd_serializer.sv
// tb_sd_cmd_serializer: table + random frames on DIV=1 and DIV=4 instances with a CRC-7 stage model.
module tb_sd_cmd_serializer;
  logic        clk = 0;
  logic        rst = 0;
  logic [1:0]  start_w = '0;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic [1:0]  ready_w, sda_o_w, sda_oe_w, crc_rst_w, crc_en_w, crc_bit_w, done_w;
  logic [6:0]  crc_m [2];
`ifdef SD_CMD_SERIALIZER_ABORT_EN
  logic [1:0]  abort_w = '0;
`endif
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  sd_cmd_serializer #(.DIV(1)) u1 (
    .clk(clk), .rst(rst),
`ifdef SD_CMD_SERIALIZER_ABORT_EN
    .abort(abort_w[0]),
`endif
    .start(start_w[0]), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .crc_i(crc_m[0]),
    .ready(ready_w[0]), .sda_o(sda_o_w[0]), .sda_oe(sda_oe_w[0]), .crc_rst(crc_rst_w[0]),
    .crc_en(crc_en_w[0]), .crc_bit(crc_bit_w[0]), .done(done_w[0]));

  sd_cmd_serializer #(.DIV(4)) u4 (
    .clk(clk), .rst(rst),
`ifdef SD_CMD_SERIALIZER_ABORT_EN
    .abort(abort_w[1]),
`endif
    .start(start_w[1]), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .crc_i(crc_m[1]),
    .ready(ready_w[1]), .sda_o(sda_o_w[1]), .sda_oe(sda_oe_w[1]), .crc_rst(crc_rst_w[1]),
    .crc_en(crc_en_w[1]), .crc_bit(crc_bit_w[1]), .done(done_w[1]));

  // Downstream CRC-7 stage (x^7+x^3+1), registered remainder
  for (genvar g = 0; g < 2; g++) begin : g_crc
    always_ff @(posedge clk)
      if (!rst || crc_rst_w[g]) crc_m[g] <= '0;
      else if (crc_en_w[g]) crc_m[g] <= {crc_m[g][5:0], 1'b0} ^ ((crc_m[g][6] ^ crc_bit_w[g]) ? 7'h09 : 7'h00);
  end

  // Reference CRC: remainder of (msg * x^7) divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int k, input logic [5:0] idx, input logic [31:0] arg, input int inj_bit,
                           output logic [47:0] fr, output int lat, output int npulse,
                           output bit ok, output bit rdy_ok);
    int d = k ? 4 : 1;
    int c = 1;
    logic q[$];
    fr = '0; lat = -1; npulse = 0; ok = 1; rdy_ok = 1;
    start_w[k] = 1; cmd_idx = idx; cmd_arg = arg;
    tick();
    start_w[k] = 0; cmd_idx = 6'($urandom); cmd_arg = $urandom;
    while (c < 1000 && lat < 0) begin
      if (done_w[k]) lat = c;
      else begin
        if (ready_w[k]) rdy_ok = 0;
        if (crc_bit_w[k] !== sda_o_w[k]) ok = 0;
        if (sda_oe_w[k]) q.push_back(sda_o_w[k]);
        if (crc_en_w[k]) npulse++;
        start_w[k] = (inj_bit >= 0 && q.size() == inj_bit * d + 1);
        tick();
        c++;
      end
    end
    start_w[k] = 0;
    if (q.size() != 48 * d) ok = 0;
    for (int j = 0; j < 48; j++)
      if (j * d < q.size()) fr[47 - j] = q[j * d];
    for (int i = 0; i < q.size(); i++)
      if (q[i] !== q[(i / d) * d]) ok = 0;
    tick();
  endtask

  typedef struct {
    int          k;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t tbl [4];
    logic [47:0] fr;
    int lat, np, k;
    bit ok, rdy_ok, seen;
    logic [5:0] idx;
    logic [31:0] arg;
    tbl[0] = '{0, 6'd0,  32'h0,        48'h40_00000000_95, 50};
    tbl[1] = '{0, 6'd8,  32'h000001AA, 48'h48_000001AA_87, 50};
    tbl[2] = '{1, 6'd17, 32'h0,        48'h51_00000000_55, 194};
    tbl[3] = '{1, 6'd0,  32'h0,        48'h40_00000000_95, 194};

    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), ready_w[i], 1);
      chk($sformatf("rst_sda%0d", i), sda_o_w[i], 1);
      chk($sformatf("rst_oe%0d", i), sda_oe_w[i], 0);
      chk($sformatf("rst_crcrst%0d", i), crc_rst_w[i], 0);
      chk($sformatf("rst_crcen%0d", i), crc_en_w[i], 0);
      chk($sformatf("rst_crcbit%0d", i), crc_bit_w[i], 1);
      chk($sformatf("rst_done%0d", i), done_w[i], 0);
    end
    rst = 1;
    tick();

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tbl%0d_ready", i), ready_w[tbl[i].k], 1);
      run_frame(tbl[i].k, tbl[i].idx, tbl[i].arg, -1, fr, lat, np, ok, rdy_ok);
      chk($sformatf("tbl%0d_frame", i), fr, tbl[i].exp);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_crc_en_pulses", i), np, 40);
      chk($sformatf("tbl%0d_bit_stable", i), ok, 1);
    end

    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 1);
      idx = 6'($urandom);
      arg = $urandom;
      chk($sformatf("rnd%0d_ready", i), ready_w[k], 1);
      run_frame(k, idx, arg, (i < 2) ? 20 : -1, fr, lat, np, ok, rdy_ok);
      chk($sformatf("rnd%0d_frame", i), fr, {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1});
      chk($sformatf("rnd%0d_latency", i), lat, k ? 194 : 50);
      chk($sformatf("rnd%0d_pulses", i), np, 40);
      chk($sformatf("rnd%0d_stable", i), ok, 1);
      chk($sformatf("rnd%0d_busy", i), rdy_ok, 1);
    end

    start_w[0] = 1; cmd_idx = 6'd0; cmd_arg = 32'h0;
    tick();
    start_w[0] = 0;
    repeat (43) tick();
    chk("crcstate_oe", sda_oe_w[0], 1);
    rst = 0;
    tick();
    chk("midrst_ready", ready_w[0], 1);
    chk("midrst_oe", sda_oe_w[0], 0);
    chk("midrst_sda", sda_o_w[0], 1);
    rst = 1;
    seen = 0;
    repeat (60) begin tick(); seen |= done_w[0]; end
    chk("midrst_no_done", seen, 0);
    run_frame(0, 6'd0, 32'h0, -1, fr, lat, np, ok, rdy_ok);
    chk("after_rst_frame", fr, 48'h40_00000000_95);

`ifdef SD_CMD_SERIALIZER_ABORT_EN
    start_w[0] = 1;
    tick();
    start_w[0] = 0;
    repeat (11) tick();
    abort_w[0] = 1;
    tick();
    abort_w[0] = 0;
    chk("abort_ready", ready_w[0], 1);
    chk("abort_crc_rst", crc_rst_w[0], 1);
    chk("abort_oe", sda_oe_w[0], 0);
    tick();
    chk("abort_crc_rst_end", crc_rst_w[0], 0);
    seen = 0;
    repeat (60) begin tick(); seen |= done_w[0]; end
    chk("abort_no_done", seen, 0);
    abort_w[0] = 1; start_w[0] = 1;
    tick();
    abort_w[0] = 0; start_w[0] = 0;
    chk("abort_prio_ready", ready_w[0], 1);
    run_frame(0, 6'd0, 32'h0, -1, fr, lat, np, ok, rdy_ok);
    chk("after_abort_frame", fr, 48'h40_00000000_95);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
